// File: rtl/spi_slv_chain_pkg.sv
// Shared types and constants for the SPI daisy-chain slave.
// Holds the FSM state enum, CRC-8 constants and the parameter limits.
package spi_slv_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;
    localparam int         CRC_BITS  = 8;

    localparam int NCH_MIN = 1;
    localparam int NCH_MAX = 16;
    localparam int DW_MIN  = 8;
    localparam int DW_MAX  = 128;

    // One MSB-first step of the serial CRC-8.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/spi_slv_chain_sync.sv
// spi_sync_edge: STG-deep synchroniser with rise/fall pulses on the
// synchronised level; one mclk-wide pulse per detected edge.
module spi_sync_edge #(
    parameter int STG = 2
) (
    input  logic mclk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STG-1:0] stg_q;
    logic           prev_q;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            stg_q  <= '0;
            prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage takes its neighbour's pre-edge value.
            stg_q  <= {stg_q[STG-2:0], din};
            prev_q <= stg_q[STG-1];
        end
    end

    assign rise = stg_q[STG-1] & ~prev_q;
    assign fall = ~stg_q[STG-1] & prev_q;

endmodule

// File: rtl/spi_slv_chain.sv
// spi_slv_chain: SPI mode-0 daisy-chain slave committing whole DW-bit words
// to NCH channels on cs_n rise. Define SPI_SLV_CHAIN_CRC_EN for a CRC-8 trailer.
module spi_slv_chain
    import spi_slv_chain_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int DW       = 64,
    parameter int SYNC_STG = 2
) (
    input  logic                mclk,
    input  logic                rst,
    input  logic                scl,
    input  logic                cs_n,
    input  logic                mosi,
    output logic                miso,
    output logic [NCH*DW-1:0]   wdao,
    output logic [NCH-1:0]      wvld,
    output logic                frm_err,
    output logic                crc_err,
    output logic                busy
);

    localparam int CHW     = NCH * DW;
    // Saturating just past the longest legal frame keeps overlong frames illegal.
    localparam int CNT_MAX = CHW + 9;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam int KW      = $clog2(NCH_MAX + 1);

    state_t              state, state_n;
    logic                scl_rise, scl_fall, cs_rise, cs_fall;
    logic [SYNC_STG-1:0] mosi_stg;
    logic                mosi_s;
    logic [CHW-1:0]      chain;
    logic [CNTW-1:0]     cnt;
    logic [CNTW-1:0]     pay_len;
    logic [KW-1:0]       k_words;
    logic                shift_en, chain_en, chain_bit, crc_ok;

    spi_sync_edge #(.STG(SYNC_STG)) u_scl_sync (
        .mclk(mclk), .rst(rst), .din(scl), .rise(scl_rise), .fall(scl_fall)
    );

    spi_sync_edge #(.STG(SYNC_STG)) u_cs_sync (
        .mclk(mclk), .rst(rst), .din(cs_n), .rise(cs_rise), .fall(cs_fall)
    );

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) mosi_stg <= '0;
        else     mosi_stg <= {mosi_stg[SYNC_STG-2:0], mosi};
    end
    assign mosi_s = mosi_stg[SYNC_STG-1];

    // A cs_n rise wins over an scl edge seen in the same cycle.
    assign shift_en = (state == ST_SHIFT) && scl_rise && !cs_rise;
    assign busy     = (state != ST_IDLE);

    always_comb begin
        // NOTE: default first so every path assigns state_n and no latch is inferred.
        state_n = state;
        case (state)
            ST_IDLE:  if (cs_fall) state_n = ST_SHIFT;
            ST_SHIFT: if (cs_rise) state_n = ST_COMMIT;
            default:  state_n = ST_IDLE;
        endcase
    end

`ifdef SPI_SLV_CHAIN_CRC_EN
    // Incoming bits wait 8 shifts in hold_q, so the trailing CRC never reaches the chain.
    logic [7:0] hold_q, crc_q;

    assign chain_en  = shift_en && (cnt >= CNTW'(CRC_BITS));
    assign chain_bit = hold_q[7];
    assign pay_len   = (cnt >= CNTW'(CRC_BITS)) ? cnt - CNTW'(CRC_BITS) : '0;
    assign crc_ok    = (crc_q == hold_q);

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            hold_q  <= '0;
            crc_q   <= CRC8_INIT;
            crc_err <= 1'b0;
        end else begin
            if (state == ST_IDLE && cs_fall) crc_q <= CRC8_INIT;
            else if (chain_en)               crc_q <= crc8_step(crc_q, hold_q[7]);
            if (shift_en) hold_q <= {hold_q[6:0], mosi_s};
            crc_err <= (state == ST_COMMIT) && (cnt != '0) && (k_words != '0) && !crc_ok;
        end
    end
`else
    assign chain_en  = shift_en;
    assign chain_bit = mosi_s;
    assign pay_len   = cnt;
    assign crc_ok    = 1'b1;
    assign crc_err   = 1'b0;
`endif

    always_comb begin
        k_words = '0;
        for (int k = 1; k <= NCH; k++)
            if (pay_len == CNTW'(k * DW)) k_words = KW'(k);
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            // NOTE: chain is a flop shift register, not a RAM, so it is reset like any flop.
            chain <= '0;
            cnt   <= '0;
            miso  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && cs_fall)
                cnt <= '0;
            else if (shift_en && cnt != CNTW'(CNT_MAX))
                cnt <= cnt + CNTW'(1);
            if (chain_en) chain <= {chain[CHW-2:0], chain_bit};
            // The chain MSB is primed at frame start so it is valid before the first scl rise.
            if (state == ST_SHIFT && !cs_rise) begin
                if (scl_fall) miso <= chain[CHW-1];
            end else if (state == ST_IDLE && cs_fall) begin
                miso <= chain[CHW-1];
            end else begin
                miso <= 1'b0;
            end
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            wdao    <= '0;
            wvld    <= '0;
            frm_err <= 1'b0;
        end else begin
            wvld    <= '0;
            frm_err <= 1'b0;
            if (state == ST_COMMIT && cnt != '0) begin
                if (k_words == '0) begin
                    frm_err <= 1'b1;
                end else if (crc_ok) begin
                    for (int j = 0; j < NCH; j++) begin
                        if (KW'(j) < k_words) begin
                            wdao[j*DW +: DW] <= chain[j*DW +: DW];
                            wvld[j]          <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slv_chain.sv
// Self-checking bench for spi_slv_chain: directed and random frames against
// a word-level model of the chain, channel outputs, strobes and miso readback.
module tb_spi_slv_chain;

    localparam int NCH      = 4;
    localparam int DW       = 64;
    localparam int SYNC_STG = 2;
    localparam int W        = NCH * DW;
    localparam int FW       = W + 16;
    localparam int HP       = 6;
`ifdef SPI_SLV_CHAIN_CRC_EN
    localparam bit CRC_EN   = 1'b1;
`else
    localparam bit CRC_EN   = 1'b0;
`endif
    localparam int CRC_LEN  = CRC_EN ? 8 : 0;

    logic           mclk, rst, scl, cs_n, mosi;
    logic           miso, frm_err, crc_err, busy;
    logic [W-1:0]   wdao;
    logic [NCH-1:0] wvld;

    int checks = 0;
    int errors = 0;
    int pcnt = 0;
    int n_wvld = 0, n_frm = 0, n_crc = 0, ev_p = 0, cs_rise_p = 0;
    logic [NCH-1:0] last_wvld = '0;

    logic [W-1:0] chain_m, wdao_m;

    spi_slv_chain #(.NCH(NCH), .DW(DW), .SYNC_STG(SYNC_STG)) dut (
        .mclk(mclk), .rst(rst), .scl(scl), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .wdao(wdao), .wvld(wvld), .frm_err(frm_err),
        .crc_err(crc_err), .busy(busy)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    always @(posedge mclk) pcnt <= pcnt + 1;

    always @(negedge mclk) begin
        if (wvld != '0) begin
            n_wvld    <= n_wvld + 1;
            last_wvld <= wvld;
            ev_p      <= pcnt;
        end
        if (frm_err) n_frm <= n_frm + 1;
        if (crc_err) n_crc <= n_crc + 1;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] crc8_ref(input logic [FW-1:0] d, input int n);
        logic [7:0] c = 8'h00;
        for (int i = n - 1; i >= 0; i--)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction

    function automatic logic [FW-1:0] rand_bits();
        logic [FW-1:0] r;
        for (int i = 0; i < FW / 16; i++) r[i*16 +: 16] = 16'($urandom());
        return r;
    endfunction

    // Payload of p bits, CRC appended when enabled; flip >= 0 corrupts one payload bit after the CRC is taken.
    function automatic logic [FW-1:0] make_frame(input logic [FW-1:0] pay, input int p, input int flip);
        logic [FW-1:0] d;
        logic [7:0]    c;
        d = pay & ((FW'(1) << p) - FW'(1));
        c = crc8_ref(d, p);
        if (flip >= 0) d[flip] = ~d[flip];
        return CRC_EN ? ((d << 8) | FW'(c)) : d;
    endfunction

    task automatic send_frame(input logic [FW-1:0] f, input int len, input int stop_at,
                              output logic [FW-1:0] rx);
        rx   = '0;
        cs_n = 1'b0;
        repeat (HP) @(negedge mclk);
        for (int i = 0; i < len; i++) begin
            if (i == stop_at) return;
            mosi = f[len-1-i];
            repeat (HP) @(negedge mclk);
            rx[len-1-i] = miso;
            if (i == 1) check("busy_shift", W'(busy), W'(1));
            scl = 1'b1;
            repeat (HP) @(negedge mclk);
            scl = 1'b0;
        end
        repeat (HP) @(negedge mclk);
        cs_n      = 1'b1;
        cs_rise_p = pcnt;
    endtask

    task automatic do_frame(input string tag, input logic [FW-1:0] f, input int len);
        logic [FW-1:0]   rx, pay;
        logic [FW+W-1:0] t;
        logic [W-1:0]    exp_rx, exp_mask;
        int              p, k, w0, f0, c0;
        bit              legal, crc_ok;
        w0 = n_wvld; f0 = n_frm; c0 = n_crc;
        p      = len - CRC_LEN;
        pay    = f >> CRC_LEN;
        exp_rx = (len <= W) ? (chain_m >> (W - len)) : '0;
        legal  = (p > 0) && (p % DW == 0) && (p / DW <= NCH);
        k      = legal ? p / DW : 0;
        crc_ok = CRC_EN ? (crc8_ref(pay, p) == f[7:0]) : 1'b1;
        if (p > 0) begin
            t = ({FW'(0), chain_m} << p) | (FW+W)'(pay & ((FW'(1) << p) - FW'(1)));
            chain_m = t[W-1:0];
        end
        send_frame(f, len, -1, rx);
        repeat (SYNC_STG + 8) @(negedge mclk);
        exp_mask = W'((1 << k) - 1);
        if (legal && crc_ok)
            for (int j = 0; j < k; j++) wdao_m[j*DW +: DW] = chain_m[j*DW +: DW];
        check({tag, "_wvld_cycles"}, W'(n_wvld - w0), W'(legal && crc_ok));
        check({tag, "_frm_err"}, W'(n_frm - f0), W'(len != 0 && !legal));
        check({tag, "_crc_err"}, W'(n_crc - c0), W'(legal && !crc_ok));
        if (legal && crc_ok) begin
            check({tag, "_wvld"}, W'(last_wvld), exp_mask);
            check({tag, "_latency"}, W'(ev_p - cs_rise_p), W'(SYNC_STG + 2));
        end
        check({tag, "_wdao"}, wdao, wdao_m);
        check({tag, "_busy_idle"}, W'(busy), W'(0));
`ifndef SPI_SLV_CHAIN_CRC_EN
        if (len <= W) check({tag, "_miso"}, rx[W-1:0], exp_rx);
`endif
    endtask

    initial begin
        logic [FW-1:0] pay, rx;
        int            w_before, lsel, len;

        rst = 1'b1; scl = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        chain_m = '0; wdao_m = '0;
        repeat (3) @(negedge mclk);
        check("rst_wdao", wdao, '0);
        check("rst_wvld", W'(wvld), '0);
        check("rst_frm_err", W'(frm_err), '0);
        check("rst_crc_err", W'(crc_err), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_miso", W'(miso), '0);
        rst = 1'b0;
        repeat (4) @(negedge mclk);

        pay = FW'({64'h0123456789ABCDEF, 64'h1111111111111111,
                   64'h2222222222222222, 64'h3333333333333333});
        do_frame("full", make_frame(pay, 256, -1), 256 + CRC_LEN);
        check("full_ch3", W'(wdao[3*DW +: DW]), W'(64'h0123456789ABCDEF));
        check("full_ch0", W'(wdao[0 +: DW]), W'(64'h3333333333333333));

        do_frame("readback", make_frame(rand_bits(), 256, -1), 256 + CRC_LEN);

        pay = FW'({64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555});
        do_frame("partial", make_frame(pay, 128, -1), 128 + CRC_LEN);
        check("partial_ch1", W'(wdao[1*DW +: DW]), W'(64'hAAAAAAAAAAAAAAAA));
        check("partial_ch0", W'(wdao[0 +: DW]), W'(64'h5555555555555555));

        do_frame("badlen", make_frame(rand_bits(), 100, -1), 100 + CRC_LEN);
        do_frame("empty", '0, 0);

        for (int n = 0; n < 6; n++) begin
            lsel = $urandom_range(0, 5);
            if (lsel < 4) begin
                do_frame("rnd_legal", make_frame(rand_bits(), (lsel + 1) * DW, -1),
                         (lsel + 1) * DW + CRC_LEN);
            end else begin
                len = $urandom_range(1, 264);
                do_frame("rnd_any", rand_bits(), len);
            end
        end

`ifdef SPI_SLV_CHAIN_CRC_EN
        pay = rand_bits();
        do_frame("crc_good", make_frame(pay, 64, -1), 64 + CRC_LEN);
        check("crc_good_wvld_mask", W'(last_wvld), W'(4'b0001));
        do_frame("crc_bad", make_frame(pay, 64, $urandom_range(0, 63)), 64 + CRC_LEN);
`endif

        w_before = n_wvld;
        send_frame(make_frame(rand_bits(), 256, -1), 256 + CRC_LEN, 37, rx);
        rst = 1'b1;
        repeat (2) @(negedge mclk);
        check("midrst_wdao", wdao, '0);
        check("midrst_wvld", W'(wvld), '0);
        check("midrst_busy", W'(busy), '0);
        check("midrst_miso", W'(miso), '0);
        check("midrst_frm_err", W'(frm_err), '0);
        cs_n = 1'b1; scl = 1'b0; mosi = 1'b0;
        chain_m = '0; wdao_m = '0;
        repeat (3) @(negedge mclk);
        rst = 1'b0;
        repeat (4) @(negedge mclk);
        check("midrst_no_strobe", W'(n_wvld - w_before), '0);
        do_frame("after_rst", make_frame(rand_bits(), 256, -1), 256 + CRC_LEN);
        check("after_rst_wvld_mask", W'(last_wvld), W'(4'b1111));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
